mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 65 ++++++
 rtl/mc_decode.sv | 41 ++++
 rtl/mc_control.sv | 143 ++++++++++++++
 tb/tb_mc_control.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// opcode/funct fields, datapath select codes and the instruction-class vector.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_LUI  = 4'd4;

  localparam logic [2:0] M2R_ALU  = 3'd0;
  localparam logic [2:0] M2R_DM   = 3'd1;
  localparam logic [2:0] M2R_PC4  = 3'd2;

  localparam logic [2:0] RD_RT    = 3'd0;
  localparam logic [2:0] RD_RD    = 3'd1;
  localparam logic [2:0] RD_RA    = 3'd2;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_J26  = 2'd2;
  localparam logic [1:0] NPC_REG  = 2'd3;

  // Exactly one bit is set for any instruction word.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic jr;
    logic nop;
    logic illegal;
  } instr_class_t;

  function automatic logic [3:0] alu_op_for(input instr_class_t c);
    if (c.subu || c.beq) return ALU_SUB;
    if (c.ori)           return ALU_OR;
    if (c.lui)           return ALU_LUI;
    return ALU_ADD;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps the IR word to a one-hot
// instruction-class vector consumed by the controller FSM.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0]  i_instr,
  output instr_class_t o_cls
);

  logic [5:0] w_op;
  logic [5:0] w_funct;

  assign w_op    = i_instr[31:26];
  assign w_funct = i_instr[5:0];

  always_comb begin
    o_cls = '0;
    if (i_instr == 32'd0) begin
      o_cls.nop = 1'b1;
    end else begin
      case (w_op)
        OP_RTYPE: begin
          case (w_funct)
            FN_ADDU: o_cls.addu    = 1'b1;
            FN_SUBU: o_cls.subu    = 1'b1;
            FN_JR:   o_cls.jr      = 1'b1;
            default: o_cls.illegal = 1'b1;
          endcase
        end
        OP_ORI:  o_cls.ori     = 1'b1;
        OP_LUI:  o_cls.lui     = 1'b1;
        OP_LW:   o_cls.lw      = 1'b1;
        OP_SW:   o_cls.sw      = 1'b1;
        OP_BEQ:  o_cls.beq     = 1'b1;
        OP_JAL:  o_cls.jal     = 1'b1;
        default: o_cls.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle controller FSM (FETCH/DECODE/EXEC/MEM/WB) with combinational
// datapath controls. Define MC_CONTROL_MEM_STALL_EN to add the MemReady stall input.
module mc_control
  import mc_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic        Zero,
`ifdef MC_CONTROL_MEM_STALL_EN
  input  logic        MemReady,
`endif
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [2:0]  MemToReg,
  output logic [2:0]  RegDest,
  output logic        RegSrc,
  output logic        ExtendSign,
  output logic [3:0]  ALUop,
  output logic [1:0]  NPCSel,
  output logic [2:0]  State,
  output logic        Done,
  output logic        Illegal
);

  state_e       r_state;
  state_e       w_next;
  instr_class_t w_cls;
  logic         w_mem_ready;
  logic         w_alu_wb;

  mc_decode u_decode (
    .i_instr (Instr),
    .o_cls   (w_cls)
  );

  // MemReady handshake: the memory access presented in MEM completes on the
  // rising edge where MemReady=1; until then MEM holds with its controls
  // (including MemWrite for sw) unchanged. MemReady is ignored outside MEM.
`ifdef MC_CONTROL_MEM_STALL_EN
  assign w_mem_ready = MemReady;
`else
  assign w_mem_ready = 1'b1;
`endif

  assign w_alu_wb = w_cls.addu | w_cls.subu | w_cls.ori | w_cls.lui;
  assign State    = r_state;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_FETCH;
    else        r_state <= w_next;
  end

  // Every control is gated by RESET so an aborted instruction cannot write.
  always_comb begin
    w_next     = ST_FETCH;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = M2R_ALU;
    RegDest    = RD_RT;
    RegSrc     = 1'b0;
    ExtendSign = 1'b0;
    ALUop      = ALU_ADD;
    NPCSel     = NPC_PC4;
    Done       = 1'b0;
    Illegal    = 1'b0;
    if (RESET) begin
      case (r_state)
        ST_FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          NPCSel  = NPC_PC4;
          w_next  = ST_DECODE;
        end
        ST_DECODE: begin
          if (w_cls.nop || w_cls.illegal) begin
            Done    = 1'b1;
            Illegal = w_cls.illegal;
            w_next  = ST_FETCH;
          end else begin
            w_next  = ST_EXEC;
          end
        end
        ST_EXEC: begin
          ALUop      = alu_op_for(w_cls);
          RegSrc     = w_cls.ori | w_cls.lui | w_cls.lw | w_cls.sw;
          ExtendSign = w_cls.ori;
          if (w_cls.beq) begin
            PCWrite = Zero;
            NPCSel  = Zero ? NPC_BR : NPC_PC4;
            Done    = 1'b1;
            w_next  = ST_FETCH;
          end else if (w_cls.jal) begin
            PCWrite  = 1'b1;
            NPCSel   = NPC_J26;
            RegWrite = 1'b1;
            RegDest  = RD_RA;
            MemToReg = M2R_PC4;
            Done     = 1'b1;
            w_next   = ST_FETCH;
          end else if (w_cls.jr) begin
            PCWrite = 1'b1;
            NPCSel  = NPC_REG;
            Done    = 1'b1;
            w_next  = ST_FETCH;
          end else if (w_cls.lw || w_cls.sw) begin
            w_next  = ST_MEM;
          end else if (w_alu_wb) begin
            w_next  = ST_WB;
          end else begin
            w_next  = ST_FETCH;
          end
        end
        ST_MEM: begin
          MemWrite = w_cls.sw;
          if (!(w_cls.lw || w_cls.sw)) begin
            w_next = ST_FETCH;
          end else if (!w_mem_ready) begin
            w_next = ST_MEM;
          end else if (w_cls.sw) begin
            Done   = 1'b1;
            w_next = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end
        ST_WB: begin
          RegWrite = w_alu_wb | w_cls.lw;
          MemToReg = w_cls.lw ? M2R_DM : M2R_ALU;
          RegDest  = (w_cls.addu || w_cls.subu) ? RD_RD : RD_RT;
          Done     = 1'b1;
          w_next   = ST_FETCH;
        end
        default: w_next = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: reset, table vectors, mid-instruction
// reset, optional MemReady stall, and randomized instructions vs a trace model.
module tb_mc_control;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mw;
    logic [2:0] m2r;
    logic [2:0] rd;
    logic       rs;
    logic       es;
    logic [3:0] alu;
    logic [1:0] npc;
    logic       done;
    logic       ill;
  } out_t;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          lat;
    logic        ill;
    logic        rw;
    int          mw;
  } vec_t;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_JAL = 7, K_JR = 8, K_NOP = 9, K_ILL = 10;

`ifdef MC_CONTROL_MEM_STALL_EN
  localparam int STALL_EN = 1;
`else
  localparam int STALL_EN = 0;
`endif

  logic        CLK;
  logic        RESET;
  logic [31:0] Instr;
  logic        Zero;
`ifdef MC_CONTROL_MEM_STALL_EN
  logic        MemReady;
`endif
  logic        PCWrite, IRWrite, RegWrite, MemWrite;
  logic [2:0]  MemToReg, RegDest;
  logic        RegSrc, ExtendSign;
  logic [3:0]  ALUop;
  logic [1:0]  NPCSel;
  logic [2:0]  State;
  logic        Done, Illegal;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [22:0] exp_q[$];
  logic        mon_en = 1'b0;
  int          mw_hits = 0;

  mc_control dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .Instr      (Instr),
    .Zero       (Zero),
`ifdef MC_CONTROL_MEM_STALL_EN
    .MemReady   (MemReady),
`endif
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .MemToReg   (MemToReg),
    .RegDest    (RegDest),
    .RegSrc     (RegSrc),
    .ExtendSign (ExtendSign),
    .ALUop      (ALUop),
    .NPCSel     (NPCSel),
    .State      (State),
    .Done       (Done),
    .Illegal    (Illegal)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  always @(negedge CLK) if (mon_en && MemWrite) mw_hits = mw_hits + 1;

  // ---------------- scoreboard helpers ----------------
  function automatic out_t sample();
    out_t s;
    s.st = State;   s.pcw = PCWrite; s.irw = IRWrite; s.rw = RegWrite;
    s.mw = MemWrite; s.m2r = MemToReg; s.rd = RegDest; s.rs = RegSrc;
    s.es = ExtendSign; s.alu = ALUop; s.npc = NPCSel; s.done = Done;
    s.ill = Illegal;
    return s;
  endfunction

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int classify(input logic [31:0] ins);
    int op, fn;
    op = int'(ins >> 26);
    fn = int'(ins & 32'd63);
    if (ins == 32'd0)            return K_NOP;
    if (op == 0 && fn == 33)     return K_ADDU;
    if (op == 0 && fn == 35)     return K_SUBU;
    if (op == 0 && fn == 8)      return K_JR;
    if (op == 13)                return K_ORI;
    if (op == 15)                return K_LUI;
    if (op == 35)                return K_LW;
    if (op == 43)                return K_SW;
    if (op == 4)                 return K_BEQ;
    if (op == 3)                 return K_JAL;
    return K_ILL;
  endfunction

  // Per-cycle expected controls for one instruction, FETCH through retirement.
  function automatic void model(input logic [31:0] ins, input logic z, input int nwait);
    out_t o;
    int   k;
    k = classify(ins);
    o = '0; o.st = 3'd0; o.pcw = 1'b1; o.irw = 1'b1;
    exp_q.push_back(o);
    o = '0; o.st = 3'd1;
    if (k == K_NOP || k == K_ILL) begin
      o.done = 1'b1;
      o.ill  = (k == K_ILL);
      exp_q.push_back(o);
      return;
    end
    exp_q.push_back(o);
    o = '0; o.st = 3'd2;
    o.alu = (k == K_SUBU || k == K_BEQ) ? 4'd1 : (k == K_ORI) ? 4'd2 : (k == K_LUI) ? 4'd4 : 4'd0;
    o.rs  = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW);
    o.es  = (k == K_ORI);
    if (k == K_BEQ) begin
      o.pcw = z; o.npc = z ? 2'd1 : 2'd0; o.done = 1'b1;
      exp_q.push_back(o);
      return;
    end
    if (k == K_JAL) begin
      o.pcw = 1'b1; o.npc = 2'd2; o.rw = 1'b1; o.rd = 3'd2; o.m2r = 3'd2; o.done = 1'b1;
      exp_q.push_back(o);
      return;
    end
    if (k == K_JR) begin
      o.pcw = 1'b1; o.npc = 2'd3; o.done = 1'b1;
      exp_q.push_back(o);
      return;
    end
    exp_q.push_back(o);
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= nwait; i++) begin
        o = '0; o.st = 3'd3; o.mw = (k == K_SW);
        o.done = (k == K_SW) && (i == nwait);
        exp_q.push_back(o);
      end
      if (k == K_SW) return;
    end
    o = '0; o.st = 3'd4; o.rw = 1'b1; o.done = 1'b1;
    o.m2r = (k == K_LW) ? 3'd1 : 3'd0;
    o.rd  = (k == K_ADDU || k == K_SUBU) ? 3'd1 : 3'd0;
    exp_q.push_back(o);
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins, input logic z, input int nwait,
                           output int lat, output logic saw_ill, output logic saw_rw,
                           output int mw_cycles);
    out_t e, a;
    int   idx, mem_cnt;
    model(ins, z, nwait);
    Instr = ins;
    Zero  = z;
    lat = 0; saw_ill = 1'b0; saw_rw = 1'b0; mw_cycles = 0; idx = 0; mem_cnt = 0;
    while (exp_q.size() != 0) begin
      e = out_t'(exp_q.pop_front());
`ifdef MC_CONTROL_MEM_STALL_EN
      if (e.st == 3'd3) begin
        MemReady = (mem_cnt >= nwait);
        mem_cnt++;
      end else begin
        MemReady = 1'($urandom_range(0, 1));
      end
`endif
      @(negedge CLK);
      a = sample();
      idx++;
      check($sformatf("trace %h cyc%0d", ins, idx), a, e);
      if (a.done && lat == 0) lat = idx;
      saw_ill = saw_ill | a.ill;
      saw_rw  = saw_rw | a.rw;
      if (a.mw) mw_cycles++;
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    imm = 16'($urandom); tgt = 26'($urandom);
    case ($urandom_range(0, 10))
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      2:  return {6'h0D, rs, rt, imm};
      3:  return {6'h0F, 5'd0, rt, imm};
      4:  return {6'h23, rs, rt, imm};
      5:  return {6'h2B, rs, rt, imm};
      6:  return {6'h04, rs, rt, imm};
      7:  return {6'h03, tgt};
      8:  return {6'h00, rs, 15'd0, 6'h08};
      9:  return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- test ----------------
  vec_t tbl[13];

  initial begin
    int   lat, mwc;
    logic ill, rw;

    tbl[0]  = '{32'h8C080004, 1'b0, 5, 1'b0, 1'b1, 0};  // lw
    tbl[1]  = '{32'h11090003, 1'b1, 3, 1'b0, 1'b0, 0};  // beq taken
    tbl[2]  = '{32'h11090003, 1'b0, 3, 1'b0, 1'b0, 0};  // beq not taken
    tbl[3]  = '{32'hFC000000, 1'b0, 2, 1'b1, 1'b0, 0};  // unknown opcode
    tbl[4]  = '{32'hAD090000, 1'b0, 4, 1'b0, 1'b0, 1};  // sw
    tbl[5]  = '{32'h01095021, 1'b0, 4, 1'b0, 1'b1, 0};  // addu
    tbl[6]  = '{32'h01095023, 1'b1, 4, 1'b0, 1'b1, 0};  // subu
    tbl[7]  = '{32'h3508FFFF, 1'b0, 4, 1'b0, 1'b1, 0};  // ori
    tbl[8]  = '{32'h3C081234, 1'b0, 4, 1'b0, 1'b1, 0};  // lui
    tbl[9]  = '{32'h0C000010, 1'b0, 3, 1'b0, 1'b1, 0};  // jal
    tbl[10] = '{32'h03E00008, 1'b0, 3, 1'b0, 1'b0, 0};  // jr
    tbl[11] = '{32'h00000000, 1'b0, 2, 1'b0, 1'b0, 0};  // nop
    tbl[12] = '{32'h01095020, 1'b0, 2, 1'b1, 1'b0, 0};  // add (unsupported funct)

    RESET = 1'b0;
    Instr = 32'hFFFFFFFF;
    Zero  = 1'b1;
`ifdef MC_CONTROL_MEM_STALL_EN
    MemReady = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check($sformatf("reset hold %0d", i), sample(), 23'd0);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    // First instruction after release starts in FETCH with IRWrite=1.
    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].ins, tbl[i].z, 0, lat, ill, rw, mwc);
      check_int($sformatf("latency %h z%0d", tbl[i].ins, tbl[i].z), lat, tbl[i].lat);
      check_int($sformatf("illegal %h", tbl[i].ins), int'(ill), int'(tbl[i].ill));
      check_int($sformatf("regwrite %h", tbl[i].ins), int'(rw), int'(tbl[i].rw));
      check_int($sformatf("memwrite %h", tbl[i].ins), mwc, tbl[i].mw);
    end

    // sw aborted by reset during EXEC.
    mon_en = 1'b1;
    Instr  = 32'hAD090000;
    Zero   = 1'b0;
`ifdef MC_CONTROL_MEM_STALL_EN
    MemReady = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_int($sformatf("abort st%0d", i), int'(State), i);
      if (i < 2) begin
        @(posedge CLK);
        #1;
      end
    end
    #1 RESET = 1'b0;
    #1 check("abort immediate", sample(), 23'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check($sformatf("abort hold %0d", i), sample(), 23'd0);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    run_instr(32'd0, 1'b0, 0, lat, ill, rw, mwc);
    mon_en = 1'b0;
    check_int("abort memwrite count", mw_hits, 0);

`ifdef MC_CONTROL_MEM_STALL_EN
    run_instr(32'hAD090000, 1'b0, 3, lat, ill, rw, mwc);
    check_int("stall sw memwrite cycles", mwc, 4);
    check_int("stall sw latency", lat, 7);
    run_instr(32'h8C080004, 1'b0, 2, lat, ill, rw, mwc);
    check_int("stall lw latency", lat, 7);
`endif

    for (int i = 0; i < 80; i++) begin
      logic [31:0] w;
      int          nw;
      w  = rand_instr();
      nw = (STALL_EN != 0) ? $urandom_range(0, 3) : 0;
      run_instr(w, 1'($urandom_range(0, 1)), nw, lat, ill, rw, mwc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
